// File: rtl/bit_scatter256.sv
// bit_scatter256: bit-addressable 256-bit vector store.
// Writes single bits (SET/CLR), streams a burst of bits from a start index
// with auto-increment (wrapping), or sweep-clears the vector CLR_GROUP bits
// per cycle. vec[0] is the bit selected by index 0 in the select tree.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op                00 SET, 01 CLR, 10 BURST, 11 SWEEP-CLEAR
//   cmd_addr              bit index (SET/CLR) or burst start index
//   cmd_len               burst length minus one
//   bit_valid/bit_ready   burst data handshake (ready only in BURST)
//   bit_data              burst data bit
//   vec                   stored vector [0:N_BITS-1], registered
//   busy                  high in BURST or SWEEP
//   done                  one-cycle pulse after each completed command
module bit_scatter256 #(
    parameter int unsigned N_BITS    = 256,
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned CLR_GROUP = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_op,
    input  logic [ADDR_W-1:0]   cmd_addr,
    input  logic [ADDR_W-1:0]   cmd_len,
    input  logic                bit_valid,
    input  logic                bit_data,
    output logic                bit_ready,
    output logic [0:N_BITS-1]   vec,
    output logic                busy,
    output logic                done
);

    localparam int unsigned N_GRP = N_BITS / CLR_GROUP;
    localparam int unsigned GRP_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_BURST = 2'b01,
        S_SWEEP = 2'b10
    } state_t;

    typedef enum logic [1:0] {
        OP_SET   = 2'b00,
        OP_CLR   = 2'b01,
        OP_BURST = 2'b10,
        OP_SWEEP = 2'b11
    } op_t;

    state_t             state, state_nxt;
    op_t                op;
    logic [ADDR_W-1:0]  ptr, ptr_nxt;
    logic [ADDR_W-1:0]  rem, rem_nxt;
    logic [GRP_W-1:0]   grp, grp_nxt;
    logic               done_nxt;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_idx;
    logic               wr_val;
    logic               clr_en;

    assign op = op_t'(cmd_op);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, datapath controls and done
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        rem_nxt   = rem;
        grp_nxt   = grp;
        done_nxt  = 1'b0;
        wr_en     = 1'b0;
        wr_idx    = ptr;
        wr_val    = bit_data;
        clr_en    = 1'b0;
        case (state)
            S_IDLE: begin
                if (cmd_valid) begin
                    case (op)
                        OP_SET, OP_CLR: begin
                            wr_en    = 1'b1;
                            wr_idx   = cmd_addr;
                            wr_val   = (op == OP_SET);
                            done_nxt = 1'b1;
                        end
                        OP_BURST: begin
                            ptr_nxt   = cmd_addr;
                            rem_nxt   = cmd_len;
                            state_nxt = S_BURST;
                        end
                        OP_SWEEP: begin
                            grp_nxt   = '0;
                            state_nxt = S_SWEEP;
                        end
                        default: state_nxt = S_IDLE;
                    endcase
                end
            end
            S_BURST: begin
                if (bit_valid) begin
                    wr_en   = 1'b1;
                    // ptr wraps naturally since N_BITS == 2**ADDR_W
                    ptr_nxt = ptr + ADDR_W'(1);
                    if (rem == '0) begin
                        state_nxt = S_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        rem_nxt = rem - ADDR_W'(1);
                    end
                end
            end
            S_SWEEP: begin
                clr_en  = 1'b1;
                grp_nxt = grp + GRP_W'(1);
                if (grp == GRP_W'(N_GRP - 1)) begin
                    state_nxt = S_IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Burst pointer, remaining count and sweep group
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
            rem <= '0;
            grp <= '0;
        end else begin
            ptr <= ptr_nxt;
            rem <= rem_nxt;
            grp <= grp_nxt;
        end
    end

    // Status outputs registered from the next state so they track state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_ready <= 1'b1;
            bit_ready <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            cmd_ready <= (state_nxt == S_IDLE);
            bit_ready <= (state_nxt == S_BURST);
            busy      <= (state_nxt != S_IDLE);
            done      <= done_nxt;
        end
    end

    // Vector storage: single-bit write or one group cleared per sweep cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec <= '0;
        end else begin
            if (wr_en) begin
                vec[wr_idx] <= wr_val;
            end
            for (int g = 0; g < int'(N_GRP); g++) begin
                if (clr_en && (grp == GRP_W'(g))) begin
                    vec[g*CLR_GROUP +: CLR_GROUP] <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bit_scatter256.sv
// Testbench for bit_scatter256: directed scenarios plus a random op mix
// checked against an array model of the 256-bit store.
module tb_bit_scatter256;

    localparam int unsigned N = 256;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         cmd_valid = 1'b0;
    logic         cmd_ready;
    logic [1:0]   cmd_op = 2'd0;
    logic [7:0]   cmd_addr = 8'd0;
    logic [7:0]   cmd_len = 8'd0;
    logic         bit_valid = 1'b0;
    logic         bit_data = 1'b0;
    logic         bit_ready;
    logic [0:N-1] vec;
    logic         busy;
    logic         done;

    logic [0:N-1] mdl = '0;
    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    bit_scatter256 dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
        .vec(vec), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sel256(input logic [0:N-1] v, input logic [7:0] idx);
        return v[idx];
    endfunction

    // SET (setv=1) or CLR (setv=0); leaves cmd_valid high for back-to-back use
    task automatic op_bit(input bit setv, input logic [7:0] a);
        cmd_valid = 1'b1;
        cmd_op    = setv ? 2'd0 : 2'd1;
        cmd_addr  = a;
        cmd_len   = 8'($urandom);
        chk("bit_ready_before", cmd_ready, 1);
        tick();
        mdl[a] = setv;
        chk("bit_status", {busy, bit_ready, cmd_ready, done}, 4'b0011);
        chk("bit_vec", vec, mdl);
    endtask

    task automatic idle(input int n);
        cmd_valid = 1'b0;
        for (int k = 0; k < n; k++) begin
            bit_valid = 1'($urandom);
            bit_data  = 1'($urandom);
            tick();
            chk("idle_status", {busy, bit_ready, cmd_ready, done}, 4'b0010);
            chk("idle_vec", vec, mdl);
        end
        bit_valid = 1'b0;
    endtask

    // Burst of len+1 bits (d[i] is the i-th bit) with gap idle cycles before
    // each bit; optionally holds a SET to pa while the burst runs.
    task automatic op_burst(input logic [7:0] a, input logic [7:0] len, input logic [N-1:0] d,
                            input int gap, input bit pend, input logic [7:0] pa);
        logic [7:0] p;
        p = a;
        cmd_valid = 1'b1;
        cmd_op    = 2'd2;
        cmd_addr  = a;
        cmd_len   = len;
        chk("burst_ready_before", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        if (pend) begin
            cmd_valid = 1'b1;
            cmd_op    = 2'd0;
            cmd_addr  = pa;
        end
        chk("burst_accept_status", {busy, bit_ready, cmd_ready, done}, 4'b1100);
        chk("burst_accept_vec", vec, mdl);
        for (int i = 0; i <= int'(len); i++) begin
            for (int g = 0; g < gap; g++) begin
                bit_valid = 1'b0;
                bit_data  = 1'($urandom);
                tick();
                chk("burst_gap_status", {busy, bit_ready, cmd_ready, done}, 4'b1100);
                chk("burst_gap_vec", vec, mdl);
            end
            bit_valid = 1'b1;
            bit_data  = d[i];
            tick();
            mdl[p] = d[i];
            p = p + 8'd1;
            if (i < int'(len))
                chk("burst_mid_status", {busy, bit_ready, cmd_ready, done}, 4'b1100);
            else
                chk("burst_end_status", {busy, bit_ready, cmd_ready, done}, 4'b0011);
            chk("burst_vec", vec, mdl);
        end
        bit_valid = 1'b0;
        if (pend) begin
            tick();
            mdl[pa] = 1'b1;
            chk("held_set_done", done, 1);
            chk("held_set_vec", vec, mdl);
            cmd_valid = 1'b0;
        end
    endtask

    task automatic op_sweep();
        int busy_cnt;
        busy_cnt  = 0;
        cmd_valid = 1'b1;
        cmd_op    = 2'd3;
        cmd_addr  = 8'($urandom);
        chk("sweep_ready_before", cmd_ready, 1);
        tick();
        cmd_valid = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            if (busy) busy_cnt++;
            chk("sweep_no_done", done, 0);
            tick();
            for (int k = 0; k < 16; k++) mdl[(j-1)*16 + k] = 1'b0;
            chk("sweep_vec", vec, mdl);
        end
        chk("sweep_end_status", {busy, cmd_ready, done}, 3'b011);
        chk("sweep_busy_cycles", 256'(busy_cnt), 256'(16));
        tick();
        chk("sweep_done_once", done, 0);
    endtask

    initial begin
        logic [N-1:0] d;
        logic [7:0]   a;
        int           r;

        // Reset state
        repeat (2) @(posedge clk);
        #3;
        chk("reset_vec", vec, '0);
        chk("reset_status", {busy, bit_ready, done}, 3'b000);
        rst_n = 1'b1;
        tick();
        chk("reset_release_ready", cmd_ready, 1);

        // Back-to-back SET 0, SET 255, CLR 0
        op_bit(1'b1, 8'd0);
        chk("set0", 256'(vec[0]), 256'(1));
        op_bit(1'b1, 8'd255);
        op_bit(1'b0, 8'd0);
        chk("clr0_set255", 256'({vec[0], vec[255]}), 256'(2'b01));
        idle(2);

        // Wrapping burst from 250, 10 bits
        d = 256'h3AD;
        op_burst(8'd250, 8'd9, d, 0, 1'b0, 8'd0);
        chk("wrap_hi", 256'(vec[250:255]), 256'(6'b101101));
        chk("wrap_lo", 256'(vec[0:3]), 256'(4'b0111));
        idle(1);

        // Gapped burst with a held SET accepted in the done cycle
        op_burst(8'd16, 8'd3, 256'hF, 2, 1'b1, 8'd100);
        chk("gap_bits", 256'(vec[16:19]), 256'(4'hF));
        idle(1);

        // Fill all ones then sweep-clear
        op_burst(8'd0, 8'd255, '1, 0, 1'b0, 8'd0);
        chk("fill_all", vec, '1);
        op_sweep();
        chk("sweep_all_zero", vec, '0);

        // Reset in the middle of a burst
        d = 256'($urandom) | 256'h1F;
        cmd_valid = 1'b1; cmd_op = 2'd2; cmd_addr = 8'd30; cmd_len = 8'd20;
        tick();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bit_valid = 1'b1; bit_data = d[i];
            tick();
            mdl[30 + i] = d[i];
        end
        chk("pre_abort_vec", vec, mdl);
        bit_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        mdl = '0;
        chk("abort_vec", vec, '0);
        chk("abort_status", {busy, bit_ready, cmd_ready, done}, 4'b0010);
        #2;
        rst_n = 1'b1;
        tick();
        chk("abort_idle", {busy, bit_ready, cmd_ready, done}, 4'b0010);
        idle(6);

        // Random op mix
        for (int n = 0; n < 1000; n++) begin
            r = int'($urandom_range(0, 99));
            a = 8'($urandom);
            if (r < 75) begin
                op_bit(1'($urandom), a);
            end else if (r < 97) begin
                d = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
                op_burst(a, 8'($urandom_range(0, 31)), d, int'($urandom_range(0, 2)),
                         1'($urandom), 8'($urandom));
            end else begin
                op_sweep();
            end
            if ($urandom_range(0, 3) == 0) idle(1);
        end
        idle(1);

        // Read every index through the select tree
        for (int i = 0; i < int'(N); i++) begin
            chk($sformatf("sel_%0d", i), 256'(sel256(vec, 8'(i))), 256'(mdl[i]));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bit_scatter256.md
Name: bit_scatter256

Overview:
- Bit-addressable 256-bit vector store; the write-side counterpart of the 256-to-1 bit-select tree.
- The select tree picks one bit out of a 256-bit bus by an 8-bit index. This block places bits into a 256-bit bus by an 8-bit index.
- Supports single-bit set/clear, a streamed burst of bits starting at an index with auto-increment, and a timed sweep-clear.
- vec feeds the 256-to-1 select tree and other flag consumers in C0. vec[0] is the bit selected by index 0.

Parameters:
- N_BITS, 256, vector width; must equal 2**ADDR_W.
- ADDR_W, 8, index width.
- CLR_GROUP, 16, bits cleared per cycle during sweep-clear; must divide N_BITS.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- cmd_valid  input  1  command offered.
- cmd_ready  output  1  command accepted when high with cmd_valid.
- cmd_op  input  2  00 SET bit, 01 CLR bit, 10 BURST, 11 SWEEP-CLEAR.
- cmd_addr  input  ADDR_W  target index (SET/CLR) or burst start index.
- cmd_len  input  ADDR_W  burst bit count minus 1 (0 = 1 bit, 255 = 256 bits); ignored for other ops.
- bit_valid  input  1  burst data bit offered.
- bit_data  input  1  burst data bit value.
- bit_ready  output  1  burst bit accepted when high with bit_valid.
- vec  output  N_BITS  stored vector, indexed [0:N_BITS-1]; registered.
- busy  output  1  high while in BURST or SWEEP.
- done  output  1  one-cycle pulse after any command completes.

Behaviour:
- Reset (async assert, sync release):
  - vec = all 0, state = IDLE, done = 0, busy = 0, bit_ready = 0.
  - Pointer and remaining count = 0. cmd_ready = 1 after release.
- States: IDLE, BURST, SWEEP. Outputs are decoded from state: cmd_ready = (IDLE), bit_ready = (BURST), busy = not IDLE.
- IDLE, command accepted (cmd_valid & cmd_ready) at edge k:
  - SET: vec[cmd_addr] <= 1 at edge k; stay IDLE; done high in cycle k+1.
  - CLR: vec[cmd_addr] <= 0 at edge k; stay IDLE; done high in cycle k+1.
  - Back-to-back SET/CLR: one per cycle, no bubble.
  - BURST: ptr <= cmd_addr, rem <= cmd_len, go to BURST. vec is unchanged at the accept edge.
  - SWEEP: grp <= 0, go to SWEEP.
- BURST:
  - Each edge with bit_valid high: vec[ptr] <= bit_data, ptr <= ptr+1 modulo N_BITS (index 255 wraps to 0).
  - If rem == 0: go to IDLE, done pulses next cycle. Otherwise rem <= rem-1.
  - bit_valid low: hold; no timeout.
  - Bits not written by the burst keep their prior value.
  - A 256-bit burst from any start overwrites every bit exactly once.
- SWEEP:
  - Each edge: vec[grp*CLR_GROUP +: CLR_GROUP] <= 0, grp <= grp+1.
  - After grp = N_BITS/CLR_GROUP-1 (15): go to IDLE. Sweep takes exactly 16 cycles; done pulses the cycle after.
- done: registered, exactly one cycle per completed command, never high in the cycle of acceptance.
  - Going BURST/SWEEP to IDLE: done and cmd_ready are high in the same cycle, so a new command may be accepted then.
- Ignored inputs:
  - bit_valid outside BURST: no effect.
  - cmd_valid outside IDLE: not accepted (cmd_ready low); the sender holds it.
- Reset mid-BURST or mid-SWEEP: immediate abort, vec cleared, no done pulse.
- Latency: a written bit is visible on vec the cycle after its write edge.

Test Plan:
- Reset, then SET addr 0, SET addr 255, CLR addr 0 on consecutive cycles -> vec[0]=1 then 0, vec[255]=1; three done pulses on consecutive cycles; busy stays 0.
- BURST addr 250, len 9, stream 1,0,1,1,0,1,0,1,1,1 with continuous bit_valid -> vec[250..255]=101101, vec[0..3]=0111; all other bits unchanged; done exactly 10 cycles after the first bit edge.
- BURST addr 16, len 3, bit_valid gaps of 2 cycles between bits, data 1111 -> vec[16..19]=1, cmd_ready low until completion; a SET issued during the burst is held and accepted in the done cycle.
- Fill vec all 1 via BURST addr 0 len 255, then SWEEP -> after 8 cycles vec[0..127]=0 and vec[128..255]=1; after 16 cycles all 0; done pulses once; busy high for exactly 16 cycles.
- Assert rst_n low mid-BURST after 5 bits -> vec all 0 immediately, state IDLE, no done pulse; bit_valid toggling in IDLE leaves vec unchanged.
- Random mix of 1000 ops against a software model, then read every index through the 256-to-1 select tree -> selected bit equals model bit for all 256 indices.
